// File: rtl/proc_controller.sv
// Multicycle processor control FSM: fetch/decode/execute sequencing with Moore outputs decoded from state and IR.
// Latency: 3 cycles per NOOP/STORE/ADD/SUB and 4 per LOAD, counted FETCH to FETCH; no backpressure, HALT is left only through reset.
module proc_controller (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] IR,
    output logic        PC_clr,
    output logic        PC_up,
    output logic        IR_ld,
    output logic [7:0]  D_addr,
    output logic        D_wr,
    output logic        RF_s,
    output logic [3:0]  RF_W_addr,
    output logic        RF_W_en,
    output logic [3:0]  RF_Ra_addr,
    output logic [3:0]  RF_Rb_addr,
    output logic [2:0]  ALU_s0,
    output logic [3:0]  state_out
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] w_opcode;

    assign w_opcode  = IR[15:12];
    assign state_out = r_state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = S_INIT;
        case (r_state)
            S_INIT:   w_next = S_FETCH;
            S_FETCH:  w_next = S_DECODE;
            // Undefined opcodes 6..F fall through to NOOP
            S_DECODE: begin
                case (w_opcode)
                    4'h1:    w_next = S_STORE;
                    4'h2:    w_next = S_LOAD_A;
                    4'h3:    w_next = S_ADD;
                    4'h4:    w_next = S_SUB;
                    4'h5:    w_next = S_HALT;
                    default: w_next = S_NOOP;
                endcase
            end
            S_LOAD_A: w_next = S_LOAD_B;
            S_NOOP,
            S_LOAD_B,
            S_STORE,
            S_ADD,
            S_SUB:    w_next = S_FETCH;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_INIT;
        endcase
    end

    always_comb begin
        PC_clr     = 1'b0;
        PC_up      = 1'b0;
        IR_ld      = 1'b0;
        D_addr     = 8'h00;
        D_wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_addr  = 4'h0;
        RF_W_en    = 1'b0;
        RF_Ra_addr = 4'h0;
        RF_Rb_addr = 4'h0;
        ALU_s0     = 3'b000;
        case (r_state)
            S_INIT: PC_clr = 1'b1;
            S_FETCH: begin
                IR_ld = 1'b1;
                PC_up = 1'b1;
            end
            // LOAD_A only presents the address; memory data is valid one cycle later in LOAD_B
            S_LOAD_A, S_LOAD_B: begin
                D_addr    = IR[11:4];
                RF_s      = 1'b1;
                RF_W_addr = IR[3:0];
                RF_W_en   = (r_state == S_LOAD_B);
            end
            S_STORE: begin
                D_addr     = IR[7:0];
                RF_Ra_addr = IR[11:8];
                D_wr       = 1'b1;
            end
            S_ADD, S_SUB: begin
                RF_Ra_addr = IR[11:8];
                RF_Rb_addr = IR[7:4];
                RF_W_addr  = IR[3:0];
                RF_W_en    = 1'b1;
                ALU_s0     = (r_state == S_ADD) ? 3'b001 : 3'b010;
            end
            default: ;
        endcase
    end

endmodule
